// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encoding and default widths for the fetch sequencer
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_t;

    localparam int kPcW       = 10;
    localparam int kStartAddr = 0;

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// rtl/fetch_sequencer_pc_next_calc.sv - next-PC selection: Halt > Jump > taken Branch > PC+1, all wrapping mod 2^PC_W
module pc_next_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W  = kPcW,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_halt,
    input  logic             i_jump,
    input  logic             i_branch_en,
    input  logic             i_zero,
    input  logic [PC_W-1:0]  i_target,
    input  logic [OFF_W-1:0] i_offset,
    output logic [PC_W-1:0]  o_next_pc
);

    logic [PC_W-1:0] w_off_ext;

    // Size-casting a signed operand sign-extends it to the PC width.
    assign w_off_ext = PC_W'($signed(i_offset));

    always_comb begin
        o_next_pc = i_pc + 1'b1;
        if (i_halt) begin
            o_next_pc = i_pc;
        end else if (i_jump) begin
            o_next_pc = i_target;
        end else if (i_branch_en && i_zero) begin
            o_next_pc = i_pc + w_off_ext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and IDLE/RUN/DONE lifecycle for the single-cycle core
// Optional watchdog enabled by defining FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W        = kPcW,
    parameter int START_ADDR  = kStartAddr,
    parameter int OFF_W       = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_jump,
    input  logic             i_branch_en,
    input  logic             i_zero,
    input  logic [PC_W-1:0]  i_target,
    input  logic [OFF_W-1:0] i_offset,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_exec_en,
    output logic             o_done,
    output logic [CNT_W-1:0] o_instr_count,
    output logic             o_timeout
);

    localparam logic [PC_W-1:0] kStart = PC_W'(START_ADDR);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_wd_fire;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .i_pc        (r_pc),
        .i_halt      (i_halt),
        .i_jump      (i_jump),
        .i_branch_en (i_branch_en),
        .i_zero      (i_zero),
        .i_target    (i_target),
        .i_offset    (i_offset),
        .o_next_pc   (w_next_pc)
    );

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;

    // Fires on the TIMEOUT_CYC-th RUN cycle since Start; that instruction is squashed.
    assign w_wd_fire = (r_state == SEQ_RUN) && !i_start && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
    assign o_timeout = r_timeout;
`else
    assign w_wd_fire = 1'b0;
    assign o_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    assign o_exec_en     = (r_state == SEQ_RUN) && !i_stall && !i_start && !w_wd_fire;
    assign o_pc          = r_pc;
    assign o_done        = r_done;
    assign o_instr_count = r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= SEQ_IDLE;
            r_pc      <= kStart;
            r_done    <= 1'b0;
            r_cnt     <= '0;
`ifdef FETCH_SEQ_TIMEOUT_EN
            r_wdog    <= '0;
            r_timeout <= 1'b0;
`endif
        end else if (i_start) begin
            r_state   <= SEQ_RUN;
            r_pc      <= kStart;
            r_done    <= 1'b0;
            r_cnt     <= '0;
`ifdef FETCH_SEQ_TIMEOUT_EN
            r_wdog    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                SEQ_RUN: begin
`ifdef FETCH_SEQ_TIMEOUT_EN
                    r_wdog <= r_wdog + 1'b1;
                    if (w_wd_fire) begin
                        r_state   <= SEQ_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
`endif
                    if (o_exec_en) begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_pc <= w_next_pc;
                        if (i_halt) begin
                            r_state <= SEQ_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
